// File: rtl/sid_io_writer.sv
// Replays queued SID register writes onto the Z80-style I/O bus as OUT cycles to
// {BASE_HI, 2'b00, chip, reg}, after a BUSRQ/grant handshake.
module sid_io_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  BASE_HI    = 8'hF8,
  parameter int unsigned IORQ_T     = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        phi_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_chip,
  input  logic [4:0]  req_reg,
  input  logic [7:0]  req_data,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        iorq_n,
  output logic        wr_n,
  output logic        busy,
  output logic        drop_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] SETUP   = 3'd2;
  localparam logic [2:0] STROBE  = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;

  localparam logic [2:0] StrobeLast = 3'(IORQ_T - 1);

  // Entry layout: {chip, reg[4:0], data[7:0]}
  logic [13:0]     fifo_mem [FIFO_DEPTH];
  logic [13:0]     head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [2:0]  state_q, state_d;
  logic [2:0]  tcnt_q, tcnt_d;
  logic        bus_req_q, bus_req_d;
  logic        strobe_n_q, strobe_n_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        drop_q;
  logic        ready_en_q;

  logic empty, full, accept, push, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign req_ready = ready_en_q && !full;
  assign accept    = req_valid && req_ready;
  // Registers 0x19..0x1F are read-only on the SID; such writes are dropped, not queued.
  assign push      = accept && (req_reg < 5'h19);
  assign head      = fifo_mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {req_chip, req_reg, req_data};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      if (accept && !push) drop_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bus_req_d  = bus_req_q;
    strobe_n_d = strobe_n_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = REQ;
          bus_req_d = 1'b1;
        end
      end
      REQ: begin
        if (phi_en && bus_ack) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (phi_en) begin
          state_d    = STROBE;
          strobe_n_d = 1'b0;
          tcnt_d     = '0;
        end
      end
      STROBE: begin
        if (phi_en) begin
          if (tcnt_q == StrobeLast) begin
            strobe_n_d = 1'b1;
            state_d    = HOLD;
          end else begin
            tcnt_d = tcnt_q + 3'd1;
          end
        end
      end
      HOLD: begin
        // A lost grant never aborts a write in flight; it only blocks the next one here.
        if (phi_en) begin
          if (!empty && bus_ack) begin
            pop     = 1'b1;
            state_d = SETUP;
          end else begin
            state_d   = RELEASE;
            bus_req_d = 1'b0;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d    = IDLE;
        bus_req_d  = 1'b0;
        strobe_n_d = 1'b1;
      end
    endcase
    if (pop) begin
      addr_d = {BASE_HI, 2'b00, head[13:8]};
      dout_d = head[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      bus_req_q  <= 1'b0;
      strobe_n_q <= 1'b1;
      addr_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bus_req_q  <= bus_req_d;
      strobe_n_q <= strobe_n_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
    end
  end

  assign bus_req  = bus_req_q;
  assign iorq_n   = strobe_n_q;
  assign wr_n     = strobe_n_q;
  assign addr     = addr_q;
  assign dout     = dout_q;
  assign drop_err = drop_q;
  assign busy     = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_sid_io_writer.sv
// Directed bench for sid_io_writer: a bus monitor logs every completed OUT cycle,
// and logged writes are compared against a table of hand-computed addresses.
module tb_sid_io_writer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        phi_en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_chip = 1'b0;
  logic [4:0]  req_reg = '0;
  logic [7:0]  req_data = '0;
  logic        bus_ack = 1'b0;
  logic        req_ready, bus_req, iorq_n, wr_n, busy, drop_err;
  logic [15:0] addr;
  logic [7:0]  dout;

  int checks = 0;
  int errors = 0;

  sid_io_writer #(
    .FIFO_DEPTH(8),
    .BASE_HI   (8'hF8),
    .IORQ_T    (3)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .phi_en   (phi_en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_chip (req_chip),
    .req_reg  (req_reg),
    .req_data (req_data),
    .bus_req  (bus_req),
    .bus_ack  (bus_ack),
    .addr     (addr),
    .dout     (dout),
    .iorq_n   (iorq_n),
    .wr_n     (wr_n),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        chip;
    logic [4:0]  rg;
    logic [7:0]  data;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs [15];

  // Monitor state; tcount = number of phi_en edges consumed by the DUT so far.
  int          tcount = 0;
  int          phase = 0;
  logic        low = 1'b0;
  logic [15:0] cap_addr;
  logic [7:0]  cap_dout;
  int          fall_t = 0;
  int          addr_chg_t = 0;
  logic [15:0] prev_addr = '0;
  logic        prev_bus_req = 1'b0;
  int          bus_req_falls = 0;
  int          viol = 0;
  logic [15:0] log_addr [$];
  logic [7:0]  log_dout [$];
  int          log_fall [$];
  int          log_len  [$];
  int          log_lead [$];

  initial begin
    forever begin
      @(negedge clock);
      if (phi_en) tcount++;
      if (!reset_n) begin
        low = 1'b0;
      end else begin
        if (addr !== prev_addr) addr_chg_t = tcount;
        if (iorq_n !== wr_n) viol++;
        if (!low && iorq_n === 1'b0) begin
          low      = 1'b1;
          cap_addr = addr;
          cap_dout = dout;
          fall_t   = tcount;
          if (bus_req !== 1'b1) viol++;
        end else if (low && iorq_n === 1'b0) begin
          if (addr !== cap_addr || dout !== cap_dout || bus_req !== 1'b1) viol++;
        end else if (low && iorq_n === 1'b1) begin
          low = 1'b0;
          log_addr.push_back(cap_addr);
          log_dout.push_back(cap_dout);
          log_fall.push_back(fall_t);
          log_len.push_back(tcount - fall_t);
          log_lead.push_back(fall_t - addr_chg_t);
        end
        if (prev_bus_req && !bus_req) bus_req_falls++;
      end
      prev_addr    = addr;
      prev_bus_req = bus_req;
      phase  = (phase + 1) % 4;
      phi_en = (phase == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic c, input logic [4:0] r, input logic [7:0] d);
    int n = 0;
    req_chip  = c;
    req_reg   = r;
    req_data  = d;
    req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    if (!req_ready) chk("push ready timeout", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_vec(input int i);
    push(vecs[i].chip, vecs[i].rg, vecs[i].data);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    chk("idle reached", 32'(busy), 32'd0);
  endtask

  task automatic check_write(input int li, input int vi);
    if (li >= log_addr.size()) begin
      chk($sformatf("write %0d present", vi), log_addr.size(), li + 1);
      return;
    end
    chk($sformatf("w%0d addr", vi), log_addr[li], vecs[vi].exp_addr);
    chk($sformatf("w%0d dout", vi), log_dout[li], vecs[vi].exp_dout);
    chk($sformatf("w%0d strobe T", vi), log_len[li], 3);
    chk($sformatf("w%0d addr lead T", vi), log_lead[li], 1);
  endtask

  int base;
  int rf0;
  int t0;
  int ga;
  int n;

  initial begin
    vecs[0]  = '{1'b0, 5'h18, 8'h0F, 16'hF818, 8'h0F};
    vecs[1]  = '{1'b0, 5'h00, 8'h11, 16'hF800, 8'h11};
    vecs[2]  = '{1'b1, 5'h0B, 8'h22, 16'hF82B, 8'h22};
    vecs[3]  = '{1'b1, 5'h04, 8'h41, 16'hF824, 8'h41};
    vecs[4]  = '{1'b0, 5'h01, 8'hA1, 16'hF801, 8'hA1};
    vecs[5]  = '{1'b1, 5'h02, 8'hA2, 16'hF822, 8'hA2};
    vecs[6]  = '{1'b0, 5'h03, 8'hA3, 16'hF803, 8'hA3};
    vecs[7]  = '{1'b1, 5'h10, 8'hA4, 16'hF830, 8'hA4};
    vecs[8]  = '{1'b0, 5'h15, 8'hA5, 16'hF815, 8'hA5};
    vecs[9]  = '{1'b1, 5'h18, 8'hA6, 16'hF838, 8'hA6};
    vecs[10] = '{1'b0, 5'h0F, 8'hA7, 16'hF80F, 8'hA7};
    vecs[11] = '{1'b1, 5'h17, 8'hA8, 16'hF837, 8'hA8};
    vecs[12] = '{1'b0, 5'h07, 8'hA9, 16'hF807, 8'hA9};
    vecs[13] = '{1'b1, 5'h05, 8'h5A, 16'hF825, 8'h5A};
    vecs[14] = '{1'b0, 5'h16, 8'h77, 16'hF816, 8'h77};

    // Reset state
    step();
    step();
    chk("rst iorq_n", 32'(iorq_n), 32'd1);
    chk("rst wr_n", 32'(wr_n), 32'd1);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst drop_err", 32'(drop_err), 32'd0);
    chk("rst addr", 32'(addr), 32'd0);
    chk("rst dout", 32'(dout), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;
    step();
    chk("req_ready after reset", 32'(req_ready), 32'd1);

    // Single write with grant tied high
    bus_ack = 1'b1;
    base = log_addr.size();
    rf0  = bus_req_falls;
    push_vec(0);
    wait_idle();
    chk("t1 write count", log_addr.size(), base + 1);
    check_write(base, 0);
    chk("t1 bus_req low", 32'(bus_req), 32'd0);
    chk("t1 bus_req falls", bus_req_falls - rf0, 1);

    // Three back-to-back writes, no RELEASE in between
    base = log_addr.size();
    rf0  = bus_req_falls;
    push_vec(1);
    push_vec(2);
    push_vec(3);
    wait_idle();
    chk("t2 write count", log_addr.size(), base + 3);
    for (int i = 0; i < 3; i++) check_write(base + i, 1 + i);
    for (int i = 1; i < 3; i++) begin
      if (base + i < log_fall.size())
        chk($sformatf("t2 spacing %0d", i), log_fall[base + i] - log_fall[base + i - 1], 5);
    end
    chk("t2 bus_req falls", bus_req_falls - rf0, 1);

    // Fill FIFO with no grant, ninth held off until the first pop
    bus_ack = 1'b0;
    base = log_addr.size();
    for (int i = 4; i < 12; i++) push_vec(i);
    chk("t3 full req_ready", 32'(req_ready), 32'd0);
    chk("t3 bus_req while waiting", 32'(bus_req), 32'd1);
    req_chip  = vecs[12].chip;
    req_reg   = vecs[12].rg;
    req_data  = vecs[12].data;
    req_valid = 1'b1;
    repeat (8) step();
    chk("t3 ninth held off", 32'(req_ready), 32'd0);
    chk("t3 no write before grant", log_addr.size(), base);
    bus_ack = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    chk("t3 ready after pop", 32'(req_ready), 32'd1);
    chk("t3 strobe not yet low", 32'(iorq_n), 32'd1);
    step();
    req_valid = 1'b0;
    wait_idle();
    chk("t3 write count", log_addr.size(), base + 9);
    for (int i = 0; i < 9; i++) check_write(base + i, 4 + i);

    // Grant delayed 10 T-states after bus_req
    bus_ack = 1'b0;
    base = log_addr.size();
    push_vec(13);
    n = 0;
    while (!bus_req && n < 20) begin
      step();
      n++;
    end
    chk("t4 bus_req raised", 32'(bus_req), 32'd1);
    t0 = tcount;
    n  = 0;
    while (tcount < t0 + 10 && n < 200) begin
      step();
      n++;
    end
    chk("t4 no write before grant", log_addr.size(), base);
    chk("t4 strobe idle before grant", 32'(iorq_n), 32'd1);
    bus_ack = 1'b1;
    ga = tcount;
    wait_idle();
    chk("t4 write count", log_addr.size(), base + 1);
    check_write(base, 13);
    if (base < log_fall.size()) chk("t4 strobe fall T", log_fall[base], ga + 2);
    chk("t4 drop_err clear", 32'(drop_err), 32'd0);

    // Read-only register request is dropped
    base = log_addr.size();
    push(1'b0, 5'h1B, 8'hEE);
    chk("t5 drop_err set", 32'(drop_err), 32'd1);
    chk("t5 busy after drop", 32'(busy), 32'd0);
    chk("t5 req_ready after drop", 32'(req_ready), 32'd1);
    repeat (20) step();
    chk("t5 no bus cycle", log_addr.size(), base);
    chk("t5 no bus_req", 32'(bus_req), 32'd0);
    push_vec(14);
    wait_idle();
    chk("t5 write count", log_addr.size(), base + 1);
    check_write(base, 14);
    chk("t5 drop_err sticky", 32'(drop_err), 32'd1);

    // Reset mid-strobe: strobes release asynchronously, queue is lost
    base = log_addr.size();
    push_vec(0);
    push_vec(1);
    n = 0;
    while (iorq_n && n < 100) begin
      step();
      n++;
    end
    chk("t6 strobe reached", 32'(iorq_n), 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6 async iorq_n", 32'(iorq_n), 32'd1);
    chk("t6 async wr_n", 32'(wr_n), 32'd1);
    chk("t6 async bus_req", 32'(bus_req), 32'd0);
    chk("t6 async req_ready", 32'(req_ready), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    chk("t6 req_ready after release", 32'(req_ready), 32'd1);
    chk("t6 drop_err cleared", 32'(drop_err), 32'd0);
    chk("t6 busy after release", 32'(busy), 32'd0);
    repeat (60) step();
    chk("t6 no further writes", log_addr.size(), base);
    chk("t6 bus_req idle", 32'(bus_req), 32'd0);
    chk("t6 iorq_n idle", 32'(iorq_n), 32'd1);

    chk("bus protocol violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
